// File: rtl/fifo_pkg.sv
// Shared definitions for axis_sync_fifo: address-width helper and default thresholds.
package fifo_pkg;

    // Fill-level flags default to four entries from either end.
    localparam int unsigned DEF_AEMPTY_TH    = 4;
    localparam int unsigned DEF_AFULL_MARGIN = 4;

    localparam int unsigned MIN_DEPTH = 4;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    // Stored entries use the pattern struct packed {logic last; logic [W-1:0] data;},
    // declared locally by users because the width is a module parameter.

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: low ADDR_W bits address storage, the MSB toggles on each roll-over.
module fifo_ptr #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [ADDR_W:0]   ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides and a last sideband.
// Optional status outputs (level, almost_full, almost_empty) are built only with AXIS_FIFO_STATUS_EN.
module axis_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
    parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_last,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic                        m_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        almost_full,
    output logic                        almost_empty
);

    localparam int unsigned ADDR_W = addr_w(DEPTH);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    if (DEPTH < MIN_DEPTH || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("axis_sync_fifo: DEPTH must be a power of two and at least 4");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("axis_sync_fifo: DATA_W must be at least 1");
    end

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              wr_fire;
    logic              rd_fire;
    logic              full_i;
    logic              empty_i;
    entry_t            mem [DEPTH];
    entry_t            head;

    // Fire conditions use only registered state, so a full FIFO never passes through
    // and an empty FIFO never bypasses.
    always_comb begin
        empty_i = (wr_ptr == rd_ptr);
        full_i  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
        wr_fire = s_valid && !full_i;
        rd_fire = m_ready && !empty_i;
    end

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_fire),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_fire),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[ADDR_W-1:0]] <= '{last: s_last, data: s_data};
        end
    end

    always_comb begin
        head    = mem[rd_ptr[ADDR_W-1:0]];
        m_data  = head.data;
        m_last  = head.last;
        m_valid = !empty_i;
        s_ready = !full_i;
        full    = full_i;
        empty   = empty_i;
    end

`ifdef AXIS_FIFO_STATUS_EN
    localparam logic [ADDR_W:0] AFULL_LVL  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_LVL = (ADDR_W + 1)'(AEMPTY_TH);

    logic [ADDR_W:0] level_i;

    // Occupancy is derived from the pointers only, so it can never drift from them.
    always_comb begin
        level_i      = wr_ptr - rd_ptr;
        level        = level_i;
        almost_full  = (level_i >= AFULL_LVL);
        almost_empty = (level_i <= AEMPTY_LVL);
    end
`else
    always_comb begin
        level        = '0;
        almost_full  = 1'b0;
        almost_empty = 1'b0;
    end
`endif

endmodule
